axis_slot_scheduler: RTL and testbench
======================================

# axis_slot_scheduler

Credit-based destination scheduler placed in front of one input of the AXI-stream switch. It holds each incoming packet at the head, picks an enabled output with a free slot in round-robin order, stamps that output's index on `tdest` for the whole packet, and forwards the packet. Per-output slot credits are consumed when a packet is assigned and returned through a release port when a downstream consumer frees a slot.

## Interface
- `M_COUNT`, 4: number of switch outputs to schedule over.
- `DEST_WIDTH`, `$clog2(M_COUNT)`: width of `tdest` and `release_dest`.
- `SLOT_COUNT`, 8: credits per output after reset. Counter width `CW = $clog2(SLOT_COUNT+1)`.
- `DATA_WIDTH`, 64: stream data width.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `USER_WIDTH`, 1: tuser width.

Ports:
- `clk`  in  1: single clock domain.
- `rst_n`  in  1: synchronous, active-low reset.
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH: packet input.
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  out/out/out/in/out/out: packet output toward the switch.
- `m_axis_tdest`  out  DEST_WIDTH: selected output index.
- `enable_mask`  in  M_COUNT: output eligible for new assignments when its bit is 1.
- `release_valid`  in  1: return one credit. Always accepted.
- `release_dest`  in  DEST_WIDTH: output whose credit is returned.
- `credit_count`  out  M_COUNT*CW: current credits, output k at `[k*CW +: CW]`.
- `release_error`  out  1: sticky flag, cleared only by reset.

## Operation
- Two states: IDLE and SEND.
- **IDLE:**
  - `s_axis_tready=0`, `m_axis_tvalid=0`.
  - When `s_axis_tvalid=1`, search outputs in the order ptr+1, ptr+2, … mod M_COUNT. The first output with `enable_mask[k]=1` and `credit[k]>0` wins.
  - On a win: `sel<=k`, `ptr<=k`, `credit[k]` decrements, and the state goes to SEND.
  - With no candidate, stay in IDLE and re-search every cycle.
- **SEND:**
  - Combinational pass-through of data, keep, last, user and valid from s to m.
  - `s_axis_tready = m_axis_tready`.
  - `m_axis_tdest = sel`, held constant for the whole packet.
  - A handshake with `tlast=1` returns the state to IDLE.
- **Release:**
  - `release_valid=1` with `release_dest < M_COUNT` increments that credit.
  - If `release_dest >= M_COUNT`, the release is ignored and `release_error` is set.
  - If the credit is already at `SLOT_COUNT`, the increment is dropped and `release_error` is set.
- **Simultaneous assign and release on the same output:** net credit is unchanged. No error if the pre-state is `SLOT_COUNT`.
- Deasserting `enable_mask[sel]` in SEND does not abort the packet. It only affects later searches.
- A packet with a single beat (tlast on the first beat) is valid: SEND lasts until that beat handshakes.
- Arithmetic: credits never wrap. Decrement only when >0; increment only when <SLOT_COUNT.

## Timing
- Reset values:
  - state = IDLE, `ptr = M_COUNT-1` (so the first search starts at output 0), `sel = 0`.
  - All credits = `SLOT_COUNT`, `release_error = 0`.
  - `s_axis_tready = 0`, `m_axis_tvalid = 0`, `m_axis_tdest = 0`, `m_axis_tlast = 0`.
- Scheduling latency:
  - `s_axis_tvalid` seen in IDLE at cycle N → assignment registered at the edge ending N.
  - First beat is presented on m in cycle N+1, with zero added data latency after that.
  - Inter-packet gap: one IDLE cycle minimum after the tlast handshake.
- `credit_count` reflects registered values. A decrement or increment is visible the cycle after the event.
- Reset asserted mid-packet: the next cycle is IDLE, credits are restored to `SLOT_COUNT`, and `m_axis_tvalid=0`. The partial packet is truncated; upstream must also reset.
- An m-side stall (`tready=0`) in SEND holds all outputs stable. Input stability is upstream's AXI obligation.

## Test plan
- Reset, then three 4-beat packets with all enabled and `SLOT_COUNT=8` → tdest 0,1,2; `credit_count` = 7,7,7,8; one idle cycle between packets.
- `enable_mask=4'b0101`, with output 0 credit driven to 0 by 8 assignments without release → subsequent packets all go to output 2; once output 2 is also at 0, `s_axis_tready` stays 0. Release to 0 → next packet goes to 0 within 2 cycles.
- Release on output 1 while it is at 8 → credit stays 8, `release_error=1` until reset. `release_dest=5` with `M_COUNT=4` → ignored, `release_error=1`.
- Assignment to output 3 in the same cycle as a release on output 3 at credit 8 → credit stays 8, no error.
- Random `m_axis_tready` backpressure over a 16-beat packet → every beat delivered in order, tdest constant, tlast exactly once. Clearing `enable_mask[sel]` mid-packet does not cut the packet.
- `rst_n=0` during beat 3 of a packet → next cycle IDLE, all credits 8, `m_axis_tvalid=0`. The next packet goes to output 0.

Source files
------------

// File: rtl/axis_slot_scheduler.sv
// Holds each packet at the head, grants a round-robin output with a free slot credit, stamps tdest.
// Grant registered one cycle after tvalid in IDLE, then zero-latency pass-through; m-side tready stalls s-side directly.
module axis_slot_scheduler #(
    parameter int M_COUNT    = 4,
    parameter int DEST_WIDTH = $clog2(M_COUNT),
    parameter int SLOT_COUNT = 8,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    localparam int CW        = $clog2(SLOT_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,

    input  logic [M_COUNT-1:0]      enable_mask,
    input  logic                    release_valid,
    input  logic [DEST_WIDTH-1:0]   release_dest,
    output logic [M_COUNT*CW-1:0]   credit_count,
    output logic                    release_error
);

    localparam int IW = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   credit_q [M_COUNT];
    logic [CW-1:0]   credit_d [M_COUNT];
    logic            err_q, err_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            assign_go;
    logic            rel_in_range;
    logic            dec_k, inc_k;

    // Round-robin search starting just after the last granted output.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 1; i <= M_COUNT; i++) begin
            idx = IW'((int'(ptr_q) + i) % M_COUNT);
            if (!found && enable_mask[idx] && (credit_q[idx] != '0)) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign assign_go    = (state_q == IDLE) && s_axis_tvalid && found;
    assign rel_in_range = {1'b0, release_dest} < (DEST_WIDTH + 1)'(M_COUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (assign_go) state_d = SEND;
            SEND: if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tuser  = s_axis_tuser;
        m_axis_tdest  = DEST_WIDTH'(sel_q);
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        if (state_q == SEND) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            s_axis_tready = m_axis_tready;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        sel_d = sel_q;
        if (assign_go) begin
            ptr_d = win;
            sel_d = win;
        end
    end

    // A grant and a release on the same output cancel, so no overflow error there.
    always_comb begin
        err_d = err_q;
        dec_k = 1'b0;
        inc_k = 1'b0;
        if (release_valid && !rel_in_range) begin
            err_d = 1'b1;
        end
        for (int k = 0; k < M_COUNT; k++) begin
            credit_d[k] = credit_q[k];
            dec_k = assign_go && (win == IW'(k));
            inc_k = release_valid && rel_in_range && (release_dest == DEST_WIDTH'(k));
            if (dec_k && !inc_k) begin
                if (credit_q[k] != '0) begin
                    credit_d[k] = credit_q[k] - CW'(1);
                end
            end else if (inc_k && !dec_k) begin
                if (credit_q[k] == CW'(SLOT_COUNT)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[k] = credit_q[k] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= IW'(M_COUNT - 1);
            sel_q <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < M_COUNT; k++) begin
                credit_q[k] <= CW'(SLOT_COUNT);
            end
        end else begin
            ptr_q <= ptr_d;
            sel_q <= sel_d;
            err_q <= err_d;
            for (int k = 0; k < M_COUNT; k++) begin
                credit_q[k] <= credit_d[k];
            end
        end
    end

    for (genvar g = 0; g < M_COUNT; g++) begin : g_cc
        assign credit_count[g*CW +: CW] = credit_q[g];
    end

    assign release_error = err_q;

endmodule

// File: tb/tb_axis_slot_scheduler.sv
// Randomized scoreboard bench for axis_slot_scheduler against a queue/array reference model.
module tb_axis_slot_scheduler;

    localparam int M     = 4;
    localparam int DW    = 3;
    localparam int SC    = 8;
    localparam int CW    = 4;
    localparam int DATAW = 64;
    localparam int KW    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATAW-1:0]  s_axis_tdata;
    logic [KW-1:0]     s_axis_tkeep;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [0:0]        s_axis_tuser;
    logic [DATAW-1:0]  m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [0:0]        m_axis_tuser;
    logic [DW-1:0]     m_axis_tdest;
    logic [M-1:0]      enable_mask;
    logic              release_valid;
    logic [DW-1:0]     release_dest;
    logic [M*CW-1:0]   credit_count;
    logic              release_error;

    always #5 clk = ~clk;

    axis_slot_scheduler #(
        .M_COUNT(M), .DEST_WIDTH(DW), .SLOT_COUNT(SC),
        .DATA_WIDTH(DATAW), .KEEP_WIDTH(KW), .USER_WIDTH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tdest(m_axis_tdest),
        .enable_mask(enable_mask), .release_valid(release_valid), .release_dest(release_dest),
        .credit_count(credit_count), .release_error(release_error)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        user;
        logic        last;
        logic [2:0]  dest;
    } beat_t;

    beat_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mcred[M];
    int          mptr;
    logic        merr;
    logic        bp = 1'b0;
    logic        gap_chk = 1'b0;
    logic [63:0] pd[64];
    logic [7:0]  pk[64];
    logic        pu[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain credit array, round-robin pointer, sticky error.
    task automatic model_reset();
        for (int k = 0; k < M; k++) mcred[k] = SC;
        mptr = M - 1;
        merr = 1'b0;
    endtask

    function automatic int model_peek();
        for (int i = 1; i <= M; i++) begin
            int k = (mptr + i) % M;
            if (enable_mask[k] && mcred[k] > 0) return k;
        end
        return -1;
    endfunction

    task automatic model_take(input int k);
        mcred[k] = mcred[k] - 1;
        mptr = k;
    endtask

    task automatic model_release(input int d);
        if (d >= M) merr = 1'b1;
        else if (mcred[d] == SC) merr = 1'b1;
        else mcred[d] = mcred[d] + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_data(input int n);
        for (int i = 0; i < n; i++) begin
            pd[i] = {$urandom, $urandom};
            pk[i] = 8'($urandom);
            pu[i] = 1'($urandom);
        end
    endtask

    task automatic push_exp(input int n, input int d);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = pd[i]; b.keep = pk[i]; b.user = pu[i];
            b.last = (i == n - 1); b.dest = 3'(d);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_beat(input int i, input int n);
        s_axis_tdata = pd[i];
        s_axis_tkeep = pk[i];
        s_axis_tuser = pu[i];
        s_axis_tlast = (i == n - 1);
    endtask

    task automatic check_state(input string name);
        @(negedge clk);
        for (int k = 0; k < M; k++)
            check({name, "_credit"}, 64'(credit_count[k*CW +: CW]), 64'(mcred[k]));
        check({name, "_err"}, 64'(release_error), 64'(merr));
        tick();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; release_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_release(input int d);
        model_release(d);
        release_valid = 1'b1;
        release_dest  = DW'(d);
        tick();
        release_valid = 1'b0;
    endtask

    task automatic do_mid_reset();
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_mid_mvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_mid_sready", 64'(s_axis_tready), 64'(0));
        for (int k = 0; k < M; k++)
            check("rst_mid_credit", 64'(credit_count[k*CW +: CW]), 64'(SC));
        tick();
    endtask

    // Entered at a negedge with the first beat already presented.
    task automatic drive_loop(input int n, input int d, input int clear_at, input int rst_at);
        int   i  = 0;
        int   to = 0;
        logic hs;
        forever begin
            hs = s_axis_tvalid && s_axis_tready;
            tick();
            if (hs) begin
                i++;
                to = 0;
                if (i == n) break;
                if (i == clear_at) enable_mask[d] = 1'b0;
                if (i == rst_at) begin
                    do_mid_reset();
                    return;
                end
                set_beat(i, n);
            end else begin
                to++;
                if (to > 400) begin
                    check("beat_timeout", 64'(1), 64'(0));
                    break;
                end
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_packet(input int n, input int rel, input int clear_at, input int rst_at);
        int d;
        d = model_peek();
        if (d < 0) begin
            check("no_candidate", 64'(1), 64'(0));
            return;
        end
        model_take(d);
        if (rel >= 0) model_release(rel);
        gen_data(n);
        push_exp(n, d);
        set_beat(0, n);
        s_axis_tvalid = 1'b1;
        if (rel >= 0) begin
            release_valid = 1'b1;
            release_dest  = DW'(rel);
        end
        @(negedge clk);
        check("lat_idle", 64'(m_axis_tvalid), 64'(0));
        tick();
        release_valid = 1'b0;
        @(negedge clk);
        check("lat_first", 64'(m_axis_tvalid), 64'(1));
        drive_loop(n, d, clear_at, rst_at);
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pop one expected beat per m-side handshake; one idle cycle must follow tlast.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (gap_chk) begin
                check("gap_sready", 64'(s_axis_tready), 64'(0));
                check("gap_mvalid", 64'(m_axis_tvalid), 64'(0));
                gap_chk = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, e.data);
                    check("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
                    check("tuser", 64'(m_axis_tuser), 64'(e.user));
                    check("tlast", 64'(m_axis_tlast), 64'(e.last));
                    check("tdest", 64'(m_axis_tdest), 64'(e.dest));
                    if (m_axis_tlast) gap_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int seen;
        int d;
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        enable_mask = 4'hF; release_valid = 1'b0; release_dest = '0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_sready", 64'(s_axis_tready), 64'(0));
        check("rst_mvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tdest",  64'(m_axis_tdest),  64'(0));
        check("rst_tlast",  64'(m_axis_tlast),  64'(0));
        tick();
        check_state("rst");

        for (int p = 0; p < 3; p++) send_packet(4, -1, -1, -1);
        check_state("three_pkts");

        send_packet(2, 3, -1, -1);
        check_state("same_cycle_rel");

        do_release(1);
        do_release(1);
        check_state("rel_at_full");
        repeat (3) tick();
        check_state("err_sticky");

        reset_dut();
        do_release(5);
        check_state("rel_out_of_range");

        reset_dut();
        enable_mask = 4'b0101;
        for (int p = 0; p < 16; p++) send_packet($urandom_range(1, 3), -1, -1, -1);
        check_state("mask_0101_drained");

        gen_data(1);
        set_beat(0, 1);
        s_axis_tvalid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("stall_sready", 64'(s_axis_tready), 64'(0));
            check("stall_mvalid", 64'(m_axis_tvalid), 64'(0));
            tick();
        end
        model_release(0);
        d = model_peek();
        model_take(d);
        push_exp(1, d);
        release_valid = 1'b1;
        release_dest  = 3'd0;
        seen = 0;
        for (int c = 0; c < 3 && seen == 0; c++) begin
            @(negedge clk);
            if (m_axis_tvalid) seen = 1;
            else begin
                tick();
                release_valid = 1'b0;
            end
        end
        check("release_wakeup", 64'(seen), 64'(1));
        if (seen == 0) @(negedge clk);
        drive_loop(1, d, -1, -1);
        check_state("after_wakeup");

        bp = 1'b1;
        enable_mask = 4'hF;
        send_packet(16, -1, 5, -1);
        send_packet(3, -1, -1, -1);
        check_state("bp_16beat");

        for (int p = 0; p < 20; p++) begin
            repeat ($urandom_range(0, 2)) do_release($urandom_range(0, 4));
            enable_mask = 4'($urandom_range(1, 15));
            if (model_peek() < 0) begin
                enable_mask = 4'hF;
                if (model_peek() < 0) do_release(0);
            end
            send_packet($urandom_range(1, 6), -1, -1, -1);
            check_state("random_pkt");
        end

        bp = 1'b0;
        reset_dut();
        enable_mask = 4'hF;
        send_packet(6, -1, -1, 3);
        send_packet(2, -1, -1, -1);
        check_state("after_mid_reset");

        repeat (4) tick();
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
